// File: rtl/usb_pkg.sv
// Token-path definitions shared by the USB transmit scheduler and its arbiter.
// Includes the PID encodings, the packet geometry and the token image builder.
package usb_pkg;

  localparam int PKT_W             = 100;
  localparam int TOKEN_PRE_CRC_LEN = 19;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } sched_state_t;

  function automatic logic is_token_pid(input logic [3:0] pid);
    case (pid)
      PID_OUT, PID_IN, PID_SOF, PID_SETUP: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // LSB-first image: PID, its complement check nibble, address, endpoint.
  function automatic logic [PKT_W-1:0] build_token(input logic [3:0] pid,
                                                   input logic [6:0] addr,
                                                   input logic [3:0] endp);
    logic [PKT_W-1:0] img;
    img        = '0;
    img[3:0]   = pid;
    img[7:4]   = ~pid;
    img[14:8]  = addr;
    img[18:15] = endp;
    return img;
  endfunction

endpackage

// File: rtl/tx_rr_arb2.sv
// Combinational two-way round-robin pick; the caller owns the rr_ptr register.
module tx_rr_arb2 (
  input  logic [1:0] req,
  input  logic       rr_ptr,
  output logic       winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr_ptr;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/usb_tok_tx_sched.sv
// Token transmit scheduler: round-robin arbitration between two requesters,
// token image assembly, CRC load strobe and SEND/timeout/gap sequencing.
module usb_tok_tx_sched
  import usb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int IPG     = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [1:0]       req,
  input  logic [7:0]       req_pid,
  input  logic [13:0]      req_addr,
  input  logic [7:0]       req_endp,
  input  logic             tx_done,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [1:0]       err,
  output logic             pkt_ready,
  output logic [PKT_W-1:0] pkt_in,
  output logic [31:0]      pkt_len,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  // Handshake: req[i] is a level held by requester i until it sees done[i] or
  // err[i]; gnt[i] marks ownership from acceptance until SEND is left; done/err
  // are single-cycle pulses and at most one bit of each is ever set.

  localparam logic [31:0] TIMEOUT_V = 32'(TIMEOUT);
  localparam logic [31:0] IPG_LAST  = 32'(IPG - 1);

  sched_state_t     state, state_d;
  logic             rr_ptr, rr_d;
  logic             owner, owner_d;
  logic [31:0]      timer, timer_d;
  logic [31:0]      gap_cnt, gap_d;
  logic [1:0]       gnt_d, done_d, err_d;
  logic             pkt_ready_d, busy_d;
  logic [PKT_W-1:0] pkt_in_d;
  logic [31:0]      pkt_len_d;

  logic             arb_winner, arb_valid;
  logic [3:0]       sel_pid;
  logic [6:0]       sel_addr;
  logic [3:0]       sel_endp;
  logic [1:0]       win_oh, owner_oh;

  tx_rr_arb2 u_arb (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  assign sel_pid   = arb_winner ? req_pid[7:4]   : req_pid[3:0];
  assign sel_addr  = arb_winner ? req_addr[13:7] : req_addr[6:0];
  assign sel_endp  = arb_winner ? req_endp[7:4]  : req_endp[3:0];
  assign win_oh    = arb_winner ? 2'b10 : 2'b01;
  assign owner_oh  = owner ? 2'b10 : 2'b01;
  assign state_dbg = state;

  always_comb begin
    state_d     = state;
    rr_d        = rr_ptr;
    owner_d     = owner;
    timer_d     = timer;
    gap_d       = gap_cnt;
    gnt_d       = gnt;
    done_d      = 2'b00;
    err_d       = 2'b00;
    pkt_ready_d = 1'b0;
    pkt_in_d    = pkt_in;
    pkt_len_d   = pkt_len;

    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          if (is_token_pid(sel_pid)) begin
            owner_d     = arb_winner;
            gnt_d       = win_oh;
            pkt_in_d    = build_token(sel_pid, sel_addr, sel_endp);
            pkt_len_d   = 32'(TOKEN_PRE_CRC_LEN);
            pkt_ready_d = 1'b1;
            state_d     = ST_LOAD;
          end else begin
            // Rejected requester yields priority just as after a served packet.
            err_d = win_oh;
            rr_d  = ~arb_winner;
          end
        end
      end
      ST_LOAD: begin
        timer_d = 32'd1;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_done || timer == TIMEOUT_V) begin
          if (tx_done) done_d = owner_oh;
          else         err_d  = owner_oh;
          gnt_d   = 2'b00;
          rr_d    = ~owner;
          gap_d   = 32'd0;
          state_d = ST_GAP;
        end else if (timer != '1) begin
          timer_d = timer + 32'd1;
        end
      end
      ST_GAP: begin
        if (gap_cnt == IPG_LAST) state_d = ST_IDLE;
        else                     gap_d   = gap_cnt + 32'd1;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      timer     <= '0;
      gap_cnt   <= '0;
      gnt       <= '0;
      done      <= '0;
      err       <= '0;
      pkt_ready <= 1'b0;
      pkt_in    <= '0;
      pkt_len   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_d;
      owner     <= owner_d;
      timer     <= timer_d;
      gap_cnt   <= gap_d;
      gnt       <= gnt_d;
      done      <= done_d;
      err       <= err_d;
      pkt_ready <= pkt_ready_d;
      pkt_in    <= pkt_in_d;
      pkt_len   <= pkt_len_d;
      busy      <= busy_d;
    end
  end

endmodule

// File: tb/tb_usb_tok_tx_sched.sv
// Self-checking bench for usb_tok_tx_sched with TIMEOUT=8 and IPG=16.
module tb_usb_tok_tx_sched;

  localparam int TB_TIMEOUT = 8;
  localparam int TB_IPG     = 16;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req;
  logic [7:0]  req_pid;
  logic [13:0] req_addr;
  logic [7:0]  req_endp;
  logic        tx_done;
  logic [1:0]  gnt, done, err;
  logic        pkt_ready;
  logic [99:0] pkt_in;
  logic [31:0] pkt_len;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks   = 0;
  int failures = 0;
  logic [99:0] exp_q[$];

  usb_tok_tx_sched #(.TIMEOUT(TB_TIMEOUT), .IPG(TB_IPG)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .req_pid   (req_pid),
    .req_addr  (req_addr),
    .req_endp  (req_endp),
    .tx_done   (tx_done),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .pkt_ready (pkt_ready),
    .pkt_in    (pkt_in),
    .pkt_len   (pkt_len),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [99:0] exp_token(input logic [3:0] pid, input logic [6:0] addr,
                                            input logic [3:0] endp);
    return {81'd0, endp, addr, ~pid, pid};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_gnt(input int limit, output bit ok);
    int n = 0;
    while (gnt == 2'b00 && n < limit) begin
      tick();
      n++;
    end
    ok = (gnt != 2'b00);
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    int n = 0;
    while (busy && n < limit) begin
      tick();
      n++;
    end
    ok = !busy;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = 2'b00; tx_done = 1'b0;
    req_pid = '0; req_addr = '0; req_endp = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    tick();
  endtask

  // scoreboard: every load strobe consumes the next expected image
  always @(negedge clock) begin
    if (reset_n) begin
      if (pkt_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_load: pkt_in=%h with no expected packet", pkt_in);
        end else begin
          logic [99:0] e;
          e = exp_q.pop_front();
          if (pkt_in !== e || pkt_len !== 32'd19) begin
            failures++;
            $display("FAIL sb_pkt: got pkt_in=%h len=%0d, want %h len=19", pkt_in, pkt_len, e);
          end
        end
      end
      checks++;
      if ((done != 0 && err != 0) || $countones(gnt) > 1 || $countones(done) > 1 ||
          $countones(err) > 1) begin
        failures++;
        $display("FAIL onehot: gnt=%b done=%b err=%b", gnt, done, err);
      end
    end
  end

  task automatic test_reset();
    reset_n = 1'b0;
    req = 2'b00; tx_done = 1'b0;
    req_pid = '0; req_addr = '0; req_endp = '0;
    #12;
    checks++;
    if ({gnt, done, err, pkt_ready, busy, state_dbg} !== 10'd0 || pkt_in !== '0 ||
        pkt_len !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: gnt=%b done=%b err=%b rdy=%b busy=%b st=%0d len=%0d, want all 0",
               gnt, done, err, pkt_ready, busy, state_dbg, pkt_len);
    end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    int busy_cnt = 0;
    req_pid = {4'h0, 4'b0001}; req_addr = {7'h0, 7'h05}; req_endp = {4'h0, 4'h8};
    exp_q.push_back(exp_token(4'b0001, 7'h05, 4'h8));
    req = 2'b01;
    tick();
    checks++;
    if (gnt !== 2'b01 || pkt_ready !== 1'b1 || pkt_in !== 100'h405E1 || pkt_len !== 32'd19) begin
      failures++;
      $display("FAIL single_grant: gnt=%b rdy=%b pkt=%h len=%0d, want 01 1 405e1 19",
               gnt, pkt_ready, pkt_in, pkt_len);
    end
    tick();
    checks++;
    if (pkt_ready !== 1'b0 || gnt !== 2'b01 || state_dbg !== 2'd2) begin
      failures++;
      $display("FAIL single_load_len: rdy=%b gnt=%b st=%0d, want 0 01 2", pkt_ready, gnt, state_dbg);
    end
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    req = 2'b00;
    checks++;
    if (done !== 2'b01 || gnt !== 2'b00 || err !== 2'b00) begin
      failures++;
      $display("FAIL single_done: done=%b gnt=%b err=%b, want 01 00 00", done, gnt, err);
    end
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cnt++;
      tick();
    end
    checks++;
    if (busy_cnt != TB_IPG || done !== 2'b00) begin
      failures++;
      $display("FAIL single_gap_len: busy cycles=%0d done=%b, want %0d 00", busy_cnt, done, TB_IPG);
    end
    wait_idle(40, ok);
  endtask

  task automatic test_contention();
    bit ok;
    logic [1:0] want;
    do_reset();
    req_pid = {4'b1101, 4'b1001}; req_addr = {7'h7F, 7'h12}; req_endp = {4'hF, 4'h3};
    for (int i = 0; i < 4; i++)
      exp_q.push_back((i % 2 == 0) ? exp_token(4'b1001, 7'h12, 4'h3)
                                   : exp_token(4'b1101, 7'h7F, 4'hF));
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_gnt(40, ok);
      checks++;
      if (!ok || gnt !== want) begin
        failures++;
        $display("FAIL contention_gnt%0d: gnt=%b, want %b", i, gnt, want);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (i == 3) req = 2'b00;
      checks++;
      if (done !== want) begin
        failures++;
        $display("FAIL contention_done%0d: done=%b, want %b", i, done, want);
      end
    end
    wait_idle(40, ok);
  endtask

  task automatic test_bad_pid();
    bit ok;
    do_reset();
    req_pid = {4'b0010, 4'b0001}; req_addr = {7'h22, 7'h01}; req_endp = {4'h2, 4'h0};
    exp_q.push_back(exp_token(4'b0001, 7'h01, 4'h0));
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_idle(40, ok);
    req = 2'b10;
    tick();
    req = 2'b00;
    checks++;
    if (err !== 2'b10 || gnt !== 2'b00 || pkt_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL bad_pid_err: err=%b gnt=%b rdy=%b busy=%b, want 10 00 0 0",
               err, gnt, pkt_ready, busy);
    end
    tick();
    checks++;
    if (err !== 2'b00) begin
      failures++;
      $display("FAIL bad_pid_pulse: err=%b, want 00", err);
    end
    req_pid = {4'b0101, 4'b0001};
    exp_q.push_back(exp_token(4'b0001, 7'h01, 4'h0));
    req = 2'b11;
    tick();
    req = 2'b00;
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL bad_pid_rr: gnt=%b, want 01", gnt);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_idle(40, ok);
  endtask

  task automatic test_timeout();
    bit ok;
    int early = 0;
    do_reset();
    req_pid = {4'h0, 4'b0001}; req_addr = {7'h0, 7'h33}; req_endp = {4'h0, 4'h5};
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(exp_token(4'b0001, 7'h33, 4'h5));
      req = 2'b01;
      tick();
      req = 2'b00;
      tick();
      early = 0;
      for (int c = 1; c < TB_TIMEOUT; c++) begin
        tick();
        if (err !== 2'b00 || gnt !== 2'b01) early++;
      end
      checks++;
      if (early != 0) begin
        failures++;
        $display("FAIL timeout_early%0d: %0d cycles with err/gnt off, want 0", pass, early);
      end
      if (pass == 1) tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      checks++;
      if (pass == 0 && (err !== 2'b01 || done !== 2'b00 || gnt !== 2'b00 || state_dbg !== 2'd3)) begin
        failures++;
        $display("FAIL timeout_abort: err=%b done=%b gnt=%b st=%0d, want 01 00 00 3",
                 err, done, gnt, state_dbg);
      end
      if (pass == 1 && (done !== 2'b01 || err !== 2'b00 || gnt !== 2'b00)) begin
        failures++;
        $display("FAIL timeout_done_wins: done=%b err=%b gnt=%b, want 01 00 00", done, err, gnt);
      end
      wait_idle(40, ok);
    end
  endtask

  task automatic test_reset_mid_send();
    bit ok;
    do_reset();
    req_pid = {4'b1001, 4'b0001}; req_addr = {7'h44, 7'h0A}; req_endp = {4'h6, 4'h1};
    exp_q.push_back(exp_token(4'b0001, 7'h0A, 4'h1));
    req = 2'b01;
    tick();
    req = 2'b00;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wait_idle(40, ok);
    exp_q.push_back(exp_token(4'b1001, 7'h44, 4'h6));
    req = 2'b10;
    tick();
    tick();
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 2'b00 || pkt_ready !== 1'b0 || busy !== 1'b0 || pkt_in !== '0 || pkt_len !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: gnt=%b rdy=%b busy=%b pkt=%h len=%0d, want all 0",
               gnt, pkt_ready, busy, pkt_in, pkt_len);
    end
    req = 2'b00;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    exp_q.push_back(exp_token(4'b0001, 7'h0A, 4'h1));
    req = 2'b11;
    tick();
    req = 2'b00;
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_gnt: gnt=%b, want 01", gnt);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_done: done=%b, want 01", done);
    end
    wait_idle(40, ok);
  endtask

  task automatic test_stray();
    bit ok;
    int bad = 0;
    tx_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done !== 2'b00 || err !== 2'b00 || busy !== 1'b0) bad++;
    end
    tx_done = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stray_idle: %0d cycles with pulses or busy, want 0", bad);
    end
    req_pid = {4'h0, 4'b1101}; req_addr = {7'h0, 7'h60}; req_endp = {4'h0, 4'hC};
    exp_q.push_back(exp_token(4'b1101, 7'h60, 4'hC));
    req = 2'b01;
    wait_gnt(10, ok);
    tick();
    req = 2'b00;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (!ok || done !== 2'b01) begin
      failures++;
      $display("FAIL withdrawn_done: done=%b granted=%0d, want 01 1", done, ok);
    end
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    checks++;
    if (done !== 2'b00 || err !== 2'b00 || state_dbg !== 2'd3) begin
      failures++;
      $display("FAIL stray_gap: done=%b err=%b st=%0d, want 00 00 3", done, err, state_dbg);
    end
    wait_idle(40, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL gap_exit: busy=%b, want 0", busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_bad_pid();
    test_timeout();
    test_reset_mid_send();
    test_stray();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d packets never loaded, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_tok_tx_sched.md
Name: usb_tok_tx_sched

Overview:
Transmit scheduler for token packets on the CRC5/serial transmit path.
- Two independent requesters share one CRC5 calculator / bit-stuffer chain: the host transaction FSM and the SOF/housekeeping logic.
- Arbitrates round-robin between them and assembles the 100-bit, LSB-first packet image and its pre-CRC length.
- Issues the one-cycle load strobe, then sequences the transfer to completion, to timeout, or through the inter-packet gap.

Parameters:
TIMEOUT, 1024, max cycles in SEND waiting for tx_done before abort (≥2)
IPG, 16, idle cycles enforced after every packet or abort before the next grant (≥1)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
req  in  2  per-requester level request, held until done/err for that requester
req_pid  in  8  {pid1[3:0], pid0[3:0]}
req_addr  in  14  {addr1[6:0], addr0[6:0]}
req_endp  in  8  {endp1[3:0], endp0[3:0]}
tx_done  in  1  one-cycle pulse from downstream when the packet's EOP is sent
gnt  out  2  one-hot; owner of the path, held from acceptance until leaving SEND
done  out  2  one-cycle pulse to owner on successful completion
err  out  2  one-cycle pulse to owner on bad PID or timeout
pkt_ready  out  1  one-cycle load strobe to the CRC block
pkt_in  out  100  packet image, bit 0 transmitted first
pkt_len  out  32  pre-CRC bit count (PID + fields)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, timer=0, and all outputs 0 (pkt_in=0, pkt_len=0).
- All outputs are registered. The FSM has states IDLE, LOAD, SEND, GAP.
- IDLE: on an edge where req≠0, select the winner.
  - Only one request bit set: that requester wins.
  - Both set: requester rr_ptr wins.
  - Latch the winner's fields.
  - Valid token PID (OUT 4'b0001, IN 4'b1001, SOF 4'b0101, SETUP 4'b1101): set gnt[w]=1, build the packet, go to LOAD.
  - Any other PID: pulse err[w] for one cycle, no gnt and no pkt_ready, set rr_ptr=~w, stay in IDLE. The next arbitration happens no earlier than the following edge.
- Packet image:
  - pkt_in[3:0]=pid, pkt_in[7:4]=~pid
  - pkt_in[14:8]=addr, pkt_in[18:15]=endp
  - pkt_in[99:19]=0
  - pkt_len=19
  - pkt_in and pkt_len are written in the same cycle as gnt and held until the next accepted packet.
- Latency: req sampled at edge k → from edge k, gnt, pkt_in, pkt_len and pkt_ready are all valid.
- LOAD (exactly 1 cycle): pkt_ready=1. Next state SEND with timer=1; pkt_ready returns to 0.
- SEND:
  - tx_done=1: done[w] pulses, gnt→0, rr_ptr=~w, go to GAP with gap count 0.
  - Otherwise, when timer==TIMEOUT: err[w] pulses, gnt→0, rr_ptr=~w, go to GAP.
  - Otherwise: timer increments.
  - tx_done in the same cycle as the timeout reaching TIMEOUT: done takes priority, no err.
- GAP: lasts exactly IPG cycles, then IDLE. Requests are ignored during GAP.
- tx_done outside SEND: ignored, no pulses.
- Requester drops req while granted: ignored. The packet runs to done/err and the pulse is still issued.
- A requester still holding req after its done competes normally. rr_ptr has moved, so the other requester wins if it is pending.
- Never more than one bit of gnt/done/err is set, and done and err are never high in the same cycle.
- Timer is 32-bit and saturates; no wrap is possible because SEND exits at TIMEOUT.

Decomposition:
- Shared package usb_pkg:
  - typedef enum logic [3:0] pid_t (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL)
  - localparam PKT_W=100
  - localparam TOKEN_PRE_CRC_LEN=19
  - function is_token_pid
- Sub-module tx_rr_arb2: combinational 2-way round-robin pick. Inputs req[1:0] and rr_ptr; outputs winner and valid. The scheduler owns the rr_ptr register.

Test Plan:
- Single request: req0 with OUT, addr 7'h05, endp 4'h8 → at the same edge gnt=2'b01, pkt_ready for 1 cycle, pkt_in=100'h405E1, pkt_len=19. Then tx_done → done=2'b01 one cycle, then exactly 16 idle cycles with busy=1.
- Contention: req=2'b11 from reset → requester 0 served first. Requester 1 is served after tx_done + IPG. Re-raise both → requester 0 next (alternation holds over 4 packets).
- Bad PID: req1 with PID 4'b0010 (ACK) → err=2'b10 one cycle, no pkt_ready, gnt stays 0, rr_ptr=0.
- Timeout: no tx_done with TIMEOUT=8 → err[w] on the 8th SEND cycle, gnt drops, GAP entered. A tx_done on exactly the 8th cycle instead → done only.
- Reset mid-SEND: assert reset_n=0 asynchronously during SEND → gnt, pkt_ready, busy, pkt_in all 0 immediately. After release, a fresh req0 is granted normally with rr_ptr=0.
- Stray/withdrawn: tx_done in IDLE and GAP → no done/err. Dropping req0 in SEND → done[0] still pulses on tx_done.
